led_panel_scan_master: RTL and testbench
========================================

// Module: led_panel_scan_master
// PURPOSE
//  Scan-timing master for the HUB75 LED panel chain. Generates row address, column read address,
//  bitplane select, LED shift clock, latch and blank for every panel client. Clients read pixel
//  memory with these signals and forward the control lines to their panels.
//  Implements binary-code modulation: each bitplane is lit for BASE_ON<<plane cycles.
//  Swaps front/back buffers only at frame boundaries.
// PARAMETERS
//  COLOR_BITS         8  bitplanes per colour; bitplaneMst is clog2(COLOR_BITS)=3 bits wide
//  DISPLAY_ROWS_LINES 4  row address width (16 scan rows)
//  DISPLAY_COLS_LINES 6  column address width (64 columns)
//  CLK_DIV            2  CLK cycles per CLK_LED half-period; must be >= MEM_LATENCY+1
//  MEM_LATENCY        1  client memory read latency in CLK cycles
//  BASE_ON            4  lit time of bitplane 0 in CLK cycles
//  TIMER_W            16 on-timer width; BASE_ON<<(COLOR_BITS-1) must be < 2**TIMER_W
// PORTS
//  CLK           in   1   system clock (200 MHz)
//  RST           in   1   asynchronous reset, active-low
//  ENABLE        in   1   1 = scan panel; 0 = idle, panel blanked
//  swapReq       in   1   request a buffer swap; rising edge detected
//  swapAck       out  1   1-cycle pulse when backbufferMst toggles
//  frameStart    out  1   1-cycle pulse at the first shift of row 0, plane 0
//  backbufferMst out  1   client write-buffer select; clients display !backbufferMst
//  memAddrMst    out  R+C {shiftRow, column} read address to clients
//  bitplaneMst   out  3   bitplane being shifted
//  ADDR_MST      out  R   row currently latched and displayed
//  CLK_LED_MST   out  1   panel shift clock
//  BLANK_MST     out  1   1 = LEDs off
//  LATCH_MST     out  1   panel latch strobe
// BEHAVIOUR
//  All outputs registered. Reset: BLANK_MST=1; everything else 0; row/plane/column counters 0; timer 0.
//  FSM states IDLE, SHIFT, WAIT, BLANK, LATCH.
//  IDLE: BLANK_MST=1, CLK_LED_MST=0, LATCH_MST=0. On ENABLE=1: enter SHIFT at row 0, plane 0, col 0.
//   frameStart pulses on this entry.
//  SHIFT, per column c:
//   - memAddrMst={shiftRow,c} is updated on the first cycle of the column.
//   - CLK_LED_MST=0 for CLK_DIV cycles, then 1 for CLK_DIV cycles (rising edge is when data is stable).
//   - bitplaneMst is constant for the whole row shift.
//   - A row shift lasts 2*CLK_DIV*2**C cycles. CLK_LED_MST is 0 after the last column.
//  After SHIFT: go to WAIT if the on-timer is nonzero, else to BLANK.
//  WAIT: hold until the timer reaches 0, then go to BLANK.
//  BLANK: BLANK_MST=1 for 1 cycle.
//  LATCH: LATCH_MST=1 for CLK_DIV cycles; ADDR_MST<=shiftRow on entry.
//   On exit: load timer=BASE_ON<<plane, set BLANK_MST=0, and advance (row,plane).
//   Plane is the inner loop: after plane COLOR_BITS-1, plane wraps to 0 and row increments.
//   After the last row the frame wraps to row 0; frameStart pulses on that next SHIFT entry.
//   Then go to SHIFT. The next shift overlaps the current display.
//  Timer: decrements by 1 per cycle while nonzero. BLANK_MST<=1 in the cycle it reaches 0.
//  Lit time per plane is exactly BASE_ON<<plane cycles.
//  Swap:
//   - A swapReq rising edge sets a pending flag. A held level yields only one swap.
//   - Serviced at the LATCH exit that wraps the frame, or immediately in IDLE.
//   - Servicing toggles backbufferMst, pulses swapAck and clears pending.
//   - An edge in the same cycle as servicing stays pending for the next frame.
//  ENABLE=0 in any state: next cycle IDLE, BLANK_MST=1, CLK_LED/LATCH 0, timer 0, counters to 0.
//   Pending swap is kept.
//  RST assertion mid-operation: immediate reset values, pending swap lost.
// TESTING (bench params: R=1, C=2, CLK_DIV=2, BASE_ON=4, COLOR_BITS=8)
//  1. Reset, then ENABLE=1 -> frameStart pulse; 4 CLK_LED rising edges with memAddrMst 0,1,2,3;
//     BLANK 1 cycle; LATCH 2 cycles; ADDR_MST=0; BLANK_MST=0 for 4 cycles.
//  2. Full frame -> BLANK_MST low widths 4,8,..,512 per row; row order 0,1,0; frameStart every 16 rows.
//  3. Plane 7 (512 cycles) exceeds shift (16 cycles) -> FSM waits in WAIT; no LATCH pulse while BLANK_MST=0.
//  4. swapReq held high 100 cycles mid-frame -> one swapAck, exactly at frame wrap;
//     backbufferMst toggles once; no toggle at the next frame.
//  5. ENABLE=0 during LATCH -> next cycle BLANK_MST=1, LATCH_MST=0; re-enable restarts at row 0, plane 0.
//  6. RST low during SHIFT -> outputs at reset values within the same cycle (async); no CLK_LED glitch after release.

Source files
------------

// File: rtl/led_panel_scan_master.sv
// HUB75 scan-timing master: row/column/bitplane sequencing with binary-code modulation,
// LED shift clock, latch/blank generation and frame-aligned front/back buffer swapping.
module led_panel_scan_master #(
    parameter int unsigned COLOR_BITS         = 8,
    parameter int unsigned DISPLAY_ROWS_LINES = 4,
    parameter int unsigned DISPLAY_COLS_LINES = 6,
    parameter int unsigned CLK_DIV            = 2,
    parameter int unsigned MEM_LATENCY        = 1,
    parameter int unsigned BASE_ON            = 4,
    parameter int unsigned TIMER_W            = 16
) (
    input  logic                                             CLK,
    input  logic                                             RST,
    input  logic                                             ENABLE,
    input  logic                                             swapReq,
    output logic                                             swapAck,
    output logic                                             frameStart,
    output logic                                             backbufferMst,
    output logic [DISPLAY_ROWS_LINES+DISPLAY_COLS_LINES-1:0] memAddrMst,
    output logic [$clog2(COLOR_BITS)-1:0]                    bitplaneMst,
    output logic [DISPLAY_ROWS_LINES-1:0]                    ADDR_MST,
    output logic                                             CLK_LED_MST,
    output logic                                             BLANK_MST,
    output logic                                             LATCH_MST
);

    localparam int unsigned R  = DISPLAY_ROWS_LINES;
    localparam int unsigned C  = DISPLAY_COLS_LINES;
    localparam int unsigned PW = $clog2(COLOR_BITS);
    // Half-period never shorter than the client read latency, so data is stable at the rising edge.
    localparam int unsigned HALF  = (CLK_DIV < MEM_LATENCY + 1) ? MEM_LATENCY + 1 : CLK_DIV;
    localparam int unsigned DIV_W = (2 * HALF > 2) ? $clog2(2 * HALF) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(2 * HALF - 1);
    localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(HALF);
    localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(HALF - 1);
    localparam logic [PW-1:0]    PLANE_LAST = PW'(COLOR_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_WAIT,
        S_BLANK,
        S_LATCH
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [C-1:0]       col_q, col_d;
    logic [R-1:0]       row_q, row_d;
    logic [PW-1:0]      plane_q, plane_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               swap_req_q;
    logic               pending_q, pending_d;

    logic               ack_q, ack_d;
    logic               frame_q, frame_d;
    logic               bb_q, bb_d;
    logic [R+C-1:0]     mem_q, mem_d;
    logic [PW-1:0]      bp_q, bp_d;
    logic [R-1:0]       addr_q, addr_d;
    logic               clk_led_q, clk_led_d;
    logic               blank_q, blank_d;
    logic               latch_q, latch_d;

    logic               swap_edge;
    logic               frame_wrap;
    logic               wrap_exit;
    logic               service;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        col_d     = col_q;
        row_d     = row_q;
        plane_d   = plane_q;
        timer_d   = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
        addr_d    = addr_q;
        mem_d     = mem_q;
        bp_d      = bp_q;
        frame_d   = 1'b0;
        wrap_exit = 1'b0;

        swap_edge  = swapReq & ~swap_req_q;
        frame_wrap = (plane_q == PLANE_LAST) && (row_q == '1);

        if (!ENABLE) begin
            state_d = S_IDLE;
            div_d   = '0;
            col_d   = '0;
            row_d   = '0;
            plane_d = '0;
            timer_d = '0;
            mem_d   = '0;
            bp_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_SHIFT;
                    div_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                    plane_d = '0;
                    frame_d = 1'b1;
                end
                S_SHIFT: begin
                    if (div_q == DIV_LAST) begin
                        div_d = '0;
                        if (col_q == '1) begin
                            col_d   = '0;
                            state_d = (timer_d != '0) ? S_WAIT : S_BLANK;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (timer_d == '0) begin
                        state_d = S_BLANK;
                    end
                end
                S_BLANK: begin
                    state_d = S_LATCH;
                    div_d   = '0;
                    addr_d  = row_q;
                end
                S_LATCH: begin
                    if (div_q == LATCH_LAST) begin
                        // Light the plane just latched; the next row shift overlaps its on-time.
                        state_d = S_SHIFT;
                        div_d   = '0;
                        col_d   = '0;
                        timer_d = TIMER_W'(BASE_ON) << plane_q;
                        if (plane_q == PLANE_LAST) begin
                            plane_d = '0;
                            row_d   = row_q + 1'b1;
                        end else begin
                            plane_d = plane_q + 1'b1;
                        end
                        frame_d   = frame_wrap;
                        wrap_exit = frame_wrap;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (state_d == S_SHIFT) begin
            mem_d = {row_d, col_d};
            bp_d  = plane_d;
        end

        clk_led_d = (state_d == S_SHIFT) && (div_d >= DIV_HALF);
        latch_d   = (state_d == S_LATCH);
        blank_d   = (timer_d == '0);

        // An edge arriving while servicing is kept for the next frame boundary.
        service   = pending_q & ((state_q == S_IDLE) | wrap_exit);
        pending_d = (pending_q & ~service) | swap_edge;
        bb_d      = bb_q ^ service;
        ack_d     = service;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            plane_q    <= '0;
            timer_q    <= '0;
            swap_req_q <= 1'b0;
            pending_q  <= 1'b0;
            ack_q      <= 1'b0;
            frame_q    <= 1'b0;
            bb_q       <= 1'b0;
            mem_q      <= '0;
            bp_q       <= '0;
            addr_q     <= '0;
            clk_led_q  <= 1'b0;
            blank_q    <= 1'b1;
            latch_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            col_q      <= col_d;
            row_q      <= row_d;
            plane_q    <= plane_d;
            timer_q    <= timer_d;
            swap_req_q <= swapReq;
            pending_q  <= pending_d;
            ack_q      <= ack_d;
            frame_q    <= frame_d;
            bb_q       <= bb_d;
            mem_q      <= mem_d;
            bp_q       <= bp_d;
            addr_q     <= addr_d;
            clk_led_q  <= clk_led_d;
            blank_q    <= blank_d;
            latch_q    <= latch_d;
        end
    end

    assign swapAck       = ack_q;
    assign frameStart    = frame_q;
    assign backbufferMst = bb_q;
    assign memAddrMst    = mem_q;
    assign bitplaneMst   = bp_q;
    assign ADDR_MST      = addr_q;
    assign CLK_LED_MST   = clk_led_q;
    assign BLANK_MST     = blank_q;
    assign LATCH_MST     = latch_q;

endmodule

// File: tb/tb_led_panel_scan_master.sv
// Bench for led_panel_scan_master: a slot/offset timeline model predicts every output each cycle.
module tb_led_panel_scan_master;

    localparam int unsigned CB    = 8;
    localparam int unsigned RL    = 1;
    localparam int unsigned CL    = 2;
    localparam int unsigned DIV   = 2;
    localparam int unsigned BASE  = 4;
    localparam int unsigned ROWS  = 1 << RL;
    localparam int unsigned COLS  = 1 << CL;
    localparam int unsigned S     = 2 * DIV * COLS;
    localparam int unsigned SLOTS = CB * ROWS;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ENABLE;
    logic          swapReq;
    logic          swapAck;
    logic          frameStart;
    logic          backbufferMst;
    logic [RL+CL-1:0] memAddrMst;
    logic [2:0]    bitplaneMst;
    logic [RL-1:0] ADDR_MST;
    logic          CLK_LED_MST;
    logic          BLANK_MST;
    logic          LATCH_MST;

    led_panel_scan_master #(
        .COLOR_BITS        (CB),
        .DISPLAY_ROWS_LINES(RL),
        .DISPLAY_COLS_LINES(CL),
        .CLK_DIV           (DIV),
        .MEM_LATENCY       (1),
        .BASE_ON           (BASE),
        .TIMER_W           (16)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ENABLE       (ENABLE),
        .swapReq      (swapReq),
        .swapAck      (swapAck),
        .frameStart   (frameStart),
        .backbufferMst(backbufferMst),
        .memAddrMst   (memAddrMst),
        .bitplaneMst  (bitplaneMst),
        .ADDR_MST     (ADDR_MST),
        .CLK_LED_MST  (CLK_LED_MST),
        .BLANK_MST    (BLANK_MST),
        .LATCH_MST    (LATCH_MST)
    );

    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned dut_acks = 0;

    // Model: slot k shifts plane k%CB of row (k/CB)%ROWS while plane of slot k-1 is lit.
    bit          m_idle;
    int unsigned m_k, m_o;
    bit          m_pend, m_bb, m_ack, m_req_prev;
    int unsigned m_addr;

    function automatic int unsigned tprev(input int unsigned k);
        return (k == 0) ? 0 : (BASE << ((k - 1) % CB));
    endfunction

    function automatic int unsigned slot_len(input int unsigned k);
        int unsigned t;
        t = tprev(k);
        return ((t > S) ? t : S) + 1 + DIV;
    endfunction

    function automatic int unsigned row_of(input int unsigned k);
        return (k / CB) % ROWS;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (slot %0d offset %0d)", tag, obs, exp, m_k, m_o);
        end
    endtask

    task automatic model_reset();
        m_idle = 1; m_k = 0; m_o = 0;
        m_pend = 0; m_bb = 0; m_ack = 0; m_req_prev = 0; m_addr = 0;
    endtask

    task automatic model_step();
        bit cur_idle, serv, edge_seen;
        if (!RST) begin
            model_reset();
            return;
        end
        cur_idle   = m_idle;
        edge_seen  = swapReq && !m_req_prev;
        m_req_prev = swapReq;
        serv = m_pend && (cur_idle ||
               (ENABLE && m_o == slot_len(m_k) - 1 && (m_k % SLOTS) == SLOTS - 1));
        if (!ENABLE) begin
            m_idle = 1;
        end else if (cur_idle) begin
            m_idle = 0; m_k = 0; m_o = 0;
        end else begin
            m_o++;
            if (m_o == slot_len(m_k)) begin
                m_k++;
                m_o = 0;
            end
        end
        if (!m_idle && m_o == slot_len(m_k) - DIV) m_addr = row_of(m_k);
        m_pend = (m_pend && !serv) || edge_seen;
        m_bb   = m_bb ^ serv;
        m_ack  = serv;
    endtask

    task automatic check_all();
        int unsigned e_blank, e_latch, e_clk, e_mem, e_bp, e_fs, l, o;
        if (m_idle) begin
            e_blank = 1; e_latch = 0; e_clk = 0; e_mem = 0; e_bp = 0; e_fs = 0;
        end else begin
            l = slot_len(m_k);
            o = m_o;
            e_blank = (o < tprev(m_k)) ? 0 : 1;
            e_latch = (o >= l - DIV) ? 1 : 0;
            e_clk   = (o < S && (o % (2 * DIV)) >= DIV) ? 1 : 0;
            e_mem   = row_of(m_k) * COLS + ((o < S) ? o / (2 * DIV) : COLS - 1);
            e_bp    = m_k % CB;
            e_fs    = (o == 0 && (m_k % SLOTS) == 0) ? 1 : 0;
        end
        chk("BLANK_MST",     32'(BLANK_MST),     e_blank);
        chk("LATCH_MST",     32'(LATCH_MST),     e_latch);
        chk("CLK_LED_MST",   32'(CLK_LED_MST),   e_clk);
        chk("memAddrMst",    32'(memAddrMst),    e_mem);
        chk("bitplaneMst",   32'(bitplaneMst),   e_bp);
        chk("frameStart",    32'(frameStart),    e_fs);
        chk("ADDR_MST",      32'(ADDR_MST),      m_addr);
        chk("swapAck",       32'(swapAck),       32'(m_ack));
        chk("backbufferMst", 32'(backbufferMst), 32'(m_bb));
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        if (swapAck === 1'b1) dut_acks++;
        check_all();
    endtask

    task automatic run_until_slot(input int unsigned k_target, input int unsigned budget);
        int unsigned g = 0;
        while ((m_idle || m_k < k_target) && g < budget) begin
            tick();
            g++;
        end
        if (m_idle || m_k < k_target) begin
            n_checks++;
            n_fail++;
            $error("FAIL wait_slot: reached slot %0d required %0d", m_k, k_target);
        end
    endtask

    task automatic run_until_latch(input int unsigned budget);
        int unsigned g = 0;
        while (!(!m_idle && m_o == slot_len(m_k) - DIV) && g < budget) begin
            tick();
            g++;
        end
        if (g >= budget) begin
            n_checks++;
            n_fail++;
            $error("FAIL wait_latch: offset %0d required %0d", m_o, slot_len(m_k) - DIV);
        end
    endtask

    initial begin
        ENABLE  = 1'b0;
        swapReq = 1'b0;
        RST     = 1'b1;
        model_reset();
        #1 RST = 1'b0;
        #1 check_all();
        @(negedge CLK);
        repeat (3) tick();
        RST = 1'b1;
        repeat (3) tick();

        // First row shift, latch and plane-0 lit time, then full frames (row order, BCM widths).
        ENABLE = 1'b1;
        run_until_slot(SLOTS + 4, 4000);

        // Held swap request mid-frame: exactly one swap, at the frame wrap.
        dut_acks = 0;
        swapReq  = 1'b1;
        repeat (100) tick();
        swapReq = 1'b0;
        run_until_slot(3 * SLOTS + 1, 6000);
        chk("swap_ack_count", dut_acks, 1);
        chk("backbuffer_after_swap", 32'(backbufferMst), 1);

        // Disable during LATCH, swap serviced in idle, then restart from row 0 plane 0.
        run_until_latch(3000);
        ENABLE = 1'b0;
        tick();
        chk("latch_drop_disable", 32'(LATCH_MST), 0);
        chk("blank_on_disable",   32'(BLANK_MST), 1);
        tick();
        swapReq = 1'b1;
        tick();
        swapReq = 1'b0;
        repeat (2) tick();
        ENABLE = 1'b1;
        run_until_slot(2, 200);

        // Asynchronous reset in the middle of a row shift.
        repeat (5) tick();
        #1 RST = 1'b0;
        #1 model_reset();
        chk("async_blank",   32'(BLANK_MST),     1);
        chk("async_clk_led", 32'(CLK_LED_MST),   0);
        chk("async_mem",     32'(memAddrMst),    0);
        chk("async_bb",      32'(backbufferMst), 0);
        check_all();
        repeat (3) tick();
        RST = 1'b1;
        run_until_slot(1, 200);

        // Randomised enable windows and swap requests.
        for (int unsigned it = 0; it < 10; it++) begin
            int unsigned en_len, idle_len;
            en_len   = $urandom_range(40, 4500);
            idle_len = $urandom_range(1, 4);
            ENABLE   = 1'b1;
            for (int unsigned i = 0; i < en_len; i++) begin
                if ($urandom_range(0, 63) == 0) swapReq = ~swapReq;
                tick();
            end
            ENABLE = 1'b0;
            for (int unsigned i = 0; i < idle_len; i++) begin
                if ($urandom_range(0, 3) == 0) swapReq = ~swapReq;
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
